control_seq: RTL and testbench

CONTROL_SEQ -- requirements
Module: control_seq

---
 rtl/control_seq_pkg.sv | 63 ++++++
 rtl/control_seq_ring_counter.sv | 32 +++
 rtl/control_seq.sv | 146 ++++++++++++++
 tb/tb_control_seq.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_seq_pkg.sv
// Shared definitions for the control sequencer: opcodes, T-state encoding,
// one-hot ring bit positions and control-word bit positions.
package control_seq_pkg;

  // Instruction opcodes
  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // T-state index as presented on the tstate output
  typedef enum logic [2:0] {
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4,
    T5 = 3'd5,
    T6 = 3'd6
  } tstate_e;

  // Bit positions of each T-state in the one-hot ring
  localparam int RING_W  = 6;
  localparam int T1_BIT  = 0;
  localparam int T2_BIT  = 1;
  localparam int T3_BIT  = 2;
  localparam int T4_BIT  = 3;
  localparam int T5_BIT  = 4;
  localparam int T6_BIT  = 5;
  localparam logic [RING_W-1:0] RING_RESET = 6'b000001;

  // Control-word bit positions
  localparam int CW_W        = 12;
  localparam int CW_PC_INC   = 11;
  localparam int CW_PC_EN    = 10;
  localparam int CW_MAR_LOAD = 9;
  localparam int CW_RAM_EN   = 8;
  localparam int CW_IR_LOAD  = 7;
  localparam int CW_IR_EN    = 6;
  localparam int CW_A_LOAD   = 5;
  localparam int CW_A_EN     = 4;
  localparam int CW_B_LOAD   = 3;
  localparam int CW_ALU_SUB  = 2;
  localparam int CW_ALU_EN   = 1;
  localparam int CW_OUT_LOAD = 0;

  // Convert the one-hot ring to its 1-based T-state index
  function automatic tstate_e ring_to_tstate(input logic [RING_W-1:0] ring);
    tstate_e t;
    t = T1;
    for (int i = 0; i < RING_W; i++) begin
      if (ring[i]) t = tstate_e'(3'(i + 1));
    end
    return t;
  endfunction

  // True for every opcode the sequencer decodes
  function automatic logic is_defined_op(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_OUT) || (op == OP_HLT);
  endfunction

endpackage

// File: rtl/control_seq_ring_counter.sv
// Six-bit one-hot T-state ring. Resets to T1, freezes while hold is high,
// and jumps back to T1 when restart is high (early instruction end).
module ring_counter
  import control_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              restart,
  output logic [RING_W-1:0] ring_q
);

  logic [RING_W-1:0] ring_d;

  // Next ring value: hold, restart at T1, or rotate one position
  always_comb begin
    // NOTE: give every always_comb output a default first so no path can infer a latch.
    ring_d = ring_q;
    if (!hold) begin
      if (restart) ring_d = RING_RESET;
      else         ring_d = {ring_q[RING_W-2:0], ring_q[RING_W-1]};
    end
  end

  // Ring register with asynchronous reset to T1
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (rst) ring_q <= RING_RESET;
    else     ring_q <= ring_d;
  end

endmodule

// File: rtl/control_seq.sv
// Microcode-free control sequencer for a simple 8-bit accumulator CPU.
// Control lines are a combinational decode of the registered T-state and
// the opcode. Optional build macro SEQ_EARLY_END_EN shortens LDA, OUT and
// undefined-as-NOP instructions by returning to T1 after their last
// active T-state.
module control_seq
  import control_seq_pkg::*;
#(
  parameter int ILLEGAL_HALT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  output logic       pc_inc,
  output logic       pc_en,
  output logic       mar_load,
  output logic       ram_en,
  output logic       ir_load,
  output logic       ir_en,
  output logic       a_load,
  output logic       a_en,
  output logic       b_load,
  output logic       alu_sub,
  output logic       alu_en,
  output logic       out_load,
  output logic [2:0] tstate,
  output logic       halted
);

  logic [RING_W-1:0] ring_q;
  logic              halted_q;
  logic              halted_d;
  logic              halt_op;
  logic              halt_now;
  logic              restart;
  logic [CW_W-1:0]   cw;

  // Opcodes that stop the sequencer: HLT, plus undefined ones when configured
  assign halt_op  = (opcode == OP_HLT) ||
                    ((ILLEGAL_HALT != 0) && !is_defined_op(opcode));
  assign halt_now = ring_q[T4_BIT] && halt_op;

  ring_counter u_ring (
    .clk     (clk),
    .rst     (rst),
    .hold    (halted_q | halt_now),
    .restart (restart),
    .ring_q  (ring_q)
  );

`ifdef SEQ_EARLY_END_EN
  logic nop_op;
  assign nop_op = (ILLEGAL_HALT == 0) && !is_defined_op(opcode);

  // Return to T1 after the last T-state that does useful work
  always_comb begin
    restart = 1'b0;
    if (ring_q[T4_BIT] && ((opcode == OP_OUT) || nop_op)) restart = 1'b1;
    if (ring_q[T5_BIT] && (opcode == OP_LDA))             restart = 1'b1;
  end
`else
  // Fixed six-clock instruction cycle: the ring wraps on its own
  assign restart = 1'b0;
`endif

  // Sticky halt flag: set at the end of T4 of a halting opcode
  always_comb begin
    halted_d = halted_q | halt_now;
  end

  // Halt register, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) halted_q <= 1'b0;
    else     halted_q <= halted_d;
  end

  // Control-word decode from T-state and opcode; all lines low while halted
  always_comb begin
    cw = '0;
    if (!halted_q) begin
      if (ring_q[T1_BIT]) begin
        cw[CW_PC_EN]    = 1'b1;
        cw[CW_MAR_LOAD] = 1'b1;
      end
      if (ring_q[T2_BIT]) cw[CW_PC_INC] = 1'b1;
      if (ring_q[T3_BIT]) begin
        cw[CW_RAM_EN]  = 1'b1;
        cw[CW_IR_LOAD] = 1'b1;
      end
      if (ring_q[T4_BIT]) begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            cw[CW_IR_EN]    = 1'b1;
            cw[CW_MAR_LOAD] = 1'b1;
          end
          OP_OUT: begin
            cw[CW_A_EN]     = 1'b1;
            cw[CW_OUT_LOAD] = 1'b1;
          end
          default: ;
        endcase
      end
      if (ring_q[T5_BIT]) begin
        case (opcode)
          OP_LDA: begin
            cw[CW_RAM_EN] = 1'b1;
            cw[CW_A_LOAD] = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            cw[CW_RAM_EN]  = 1'b1;
            cw[CW_B_LOAD]  = 1'b1;
            cw[CW_ALU_SUB] = (opcode == OP_SUB);
          end
          default: ;
        endcase
      end
      if (ring_q[T6_BIT]) begin
        case (opcode)
          OP_ADD, OP_SUB: begin
            cw[CW_ALU_EN]  = 1'b1;
            cw[CW_A_LOAD]  = 1'b1;
            cw[CW_ALU_SUB] = (opcode == OP_SUB);
          end
          default: ;
        endcase
      end
    end
  end

  assign pc_inc   = cw[CW_PC_INC];
  assign pc_en    = cw[CW_PC_EN];
  assign mar_load = cw[CW_MAR_LOAD];
  assign ram_en   = cw[CW_RAM_EN];
  assign ir_load  = cw[CW_IR_LOAD];
  assign ir_en    = cw[CW_IR_EN];
  assign a_load   = cw[CW_A_LOAD];
  assign a_en     = cw[CW_A_EN];
  assign b_load   = cw[CW_B_LOAD];
  assign alu_sub  = cw[CW_ALU_SUB];
  assign alu_en   = cw[CW_ALU_EN];
  assign out_load = cw[CW_OUT_LOAD];

  assign tstate = ring_to_tstate(ring_q);
  assign halted = halted_q;

endmodule

// File: tb/tb_control_seq.sv
// Directed testbench for control_seq. Two instances share clock, reset and
// opcode: dut (ILLEGAL_HALT=0) and dut_ih (ILLEGAL_HALT=1).
// Control words are viewed as {pc_inc, pc_en, mar_load, ram_en, ir_load,
// ir_en, a_load, a_en, b_load, alu_sub, alu_en, out_load}.
module tb_control_seq;

`ifdef SEQ_EARLY_END_EN
  localparam int LEN_LDA      = 5;
  localparam int LEN_OUT      = 4;
  localparam int LEN_NOP      = 4;
  localparam int NOP_AFTER_T4 = 1;
`else
  localparam int LEN_LDA      = 6;
  localparam int LEN_OUT      = 6;
  localparam int LEN_NOP      = 6;
  localparam int NOP_AFTER_T4 = 5;
`endif

  // Expected control words, listed T1..T6 from the most significant slice
  localparam logic [71:0] EXP_LDA = {12'h600, 12'h800, 12'h180, 12'h240, 12'h120, 12'h000};
  localparam logic [71:0] EXP_ADD = {12'h600, 12'h800, 12'h180, 12'h240, 12'h108, 12'h022};
  localparam logic [71:0] EXP_SUB = {12'h600, 12'h800, 12'h180, 12'h240, 12'h10C, 12'h026};
  localparam logic [71:0] EXP_OUT = {12'h600, 12'h800, 12'h180, 12'h011, 12'h000, 12'h000};
  localparam logic [71:0] EXP_NOP = {12'h600, 12'h800, 12'h180, 12'h000, 12'h000, 12'h000};

  logic       clk;
  logic       rst;
  logic [3:0] opcode;

  logic pc_inc, pc_en, mar_load, ram_en, ir_load, ir_en;
  logic a_load, a_en, b_load, alu_sub, alu_en, out_load;
  logic [2:0] tstate;
  logic       halted;

  logic ih_pc_inc, ih_pc_en, ih_mar_load, ih_ram_en, ih_ir_load, ih_ir_en;
  logic ih_a_load, ih_a_en, ih_b_load, ih_alu_sub, ih_alu_en, ih_out_load;
  logic [2:0] ih_tstate;
  logic       ih_halted;

  logic [11:0] ctl;
  logic [11:0] ih_ctl;
  logic [4:0]  drivers;

  int checks = 0;
  int errors = 0;

  assign ctl = {pc_inc, pc_en, mar_load, ram_en, ir_load, ir_en,
                a_load, a_en, b_load, alu_sub, alu_en, out_load};
  assign ih_ctl = {ih_pc_inc, ih_pc_en, ih_mar_load, ih_ram_en, ih_ir_load, ih_ir_en,
                   ih_a_load, ih_a_en, ih_b_load, ih_alu_sub, ih_alu_en, ih_out_load};
  assign drivers = {pc_en, ram_en, ir_en, a_en, alu_en};

  control_seq #(.ILLEGAL_HALT(0)) dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .pc_inc(pc_inc), .pc_en(pc_en), .mar_load(mar_load), .ram_en(ram_en),
    .ir_load(ir_load), .ir_en(ir_en), .a_load(a_load), .a_en(a_en),
    .b_load(b_load), .alu_sub(alu_sub), .alu_en(alu_en), .out_load(out_load),
    .tstate(tstate), .halted(halted)
  );

  control_seq #(.ILLEGAL_HALT(1)) dut_ih (
    .clk(clk), .rst(rst), .opcode(opcode),
    .pc_inc(ih_pc_inc), .pc_en(ih_pc_en), .mar_load(ih_mar_load), .ram_en(ih_ram_en),
    .ir_load(ih_ir_load), .ir_en(ih_ir_en), .a_load(ih_a_load), .a_en(ih_a_en),
    .b_load(ih_b_load), .alu_sub(ih_alu_sub), .alu_en(ih_alu_en), .out_load(ih_out_load),
    .tstate(ih_tstate), .halted(ih_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse reset for one full clock; returns on a negedge with the ring in T1
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Step dut through one instruction from T1 and compare every T-state
  task automatic run_instr(input string name, input logic [3:0] op,
                           input int len, input logic [71:0] exp_v);
    logic [11:0] exp_w;
    int          incs;
    incs   = 0;
    opcode = op;
    for (int i = 0; i < len; i++) begin
      if (i > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      exp_w = exp_v[(5 - i) * 12 +: 12];
      checks++;
      if (tstate !== 3'(i + 1) || ctl !== exp_w || halted !== 1'b0) begin
        errors++;
        $display("FAIL %s T%0d: tstate=%0d ctl=%h halted=%b, required tstate=%0d ctl=%h halted=0",
                 name, i + 1, tstate, ctl, halted, i + 1, exp_w);
      end
      checks++;
      if ($countones(drivers) > 1) begin
        errors++;
        $display("FAIL %s T%0d bus drivers: %b, required at most one high", name, i + 1, drivers);
      end
      if (pc_inc === 1'b1) incs++;
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (tstate !== 3'd1) begin
      errors++;
      $display("FAIL %s wrap: tstate=%0d after %0d clocks, required 1", name, tstate, len);
    end
    checks++;
    if (incs != 1) begin
      errors++;
      $display("FAIL %s pc_inc pulses: %0d, required 1", name, incs);
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    opcode = 4'h1;
    @(negedge clk);
    checks++;
    if (tstate !== 3'd1 || halted !== 1'b0 || ctl !== 12'h600) begin
      errors++;
      $display("FAIL reset_state: tstate=%0d halted=%b ctl=%h, required 1 0 600", tstate, halted, ctl);
    end
    rst = 1'b0;
    // Abort an ADD in T5
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (tstate !== 3'd5 || ctl !== 12'h108) begin
      errors++;
      $display("FAIL reset_pre_t5: tstate=%0d ctl=%h, required 5 108", tstate, ctl);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (tstate !== 3'd1 || halted !== 1'b0 || ctl !== 12'h600) begin
      errors++;
      $display("FAIL reset_mid_add: tstate=%0d halted=%b ctl=%h, required 1 0 600", tstate, halted, ctl);
    end
    @(negedge clk);
    checks++;
    if (tstate !== 3'd1 || ctl !== 12'h600) begin
      errors++;
      $display("FAIL reset_held: tstate=%0d ctl=%h, required 1 600", tstate, ctl);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (tstate !== 3'd2 || ctl !== 12'h800) begin
      errors++;
      $display("FAIL reset_release: tstate=%0d ctl=%h, required 2 800", tstate, ctl);
    end
  endtask

  task automatic test_add();
    apply_reset();
    run_instr("add", 4'h1, 6, EXP_ADD);
  endtask

  task automatic test_sub();
    apply_reset();
    run_instr("sub", 4'h2, 6, EXP_SUB);
  endtask

  task automatic test_out();
    apply_reset();
    run_instr("out", 4'hE, LEN_OUT, EXP_OUT);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    run_instr("b2b_lda", 4'h0, LEN_LDA, EXP_LDA);
    run_instr("b2b_out", 4'hE, LEN_OUT, EXP_OUT);
    run_instr("b2b_add", 4'h1, 6, EXP_ADD);
  endtask

  task automatic test_hlt();
    opcode = 4'hF;
    apply_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (tstate !== 3'd4 || halted !== 1'b0 || ctl !== 12'h000) begin
      errors++;
      $display("FAIL hlt_t4: tstate=%0d halted=%b ctl=%h, required 4 0 000", tstate, halted, ctl);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 0) opcode = 4'h0;  // halt must stay sticky whatever the opcode
      checks++;
      if (tstate !== 3'd4 || halted !== 1'b1 || ctl !== 12'h000) begin
        errors++;
        $display("FAIL hlt_hold clk%0d: tstate=%0d halted=%b ctl=%h, required 4 1 000",
                 i, tstate, halted, ctl);
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if (tstate !== 3'd1 || halted !== 1'b0 || ctl !== 12'h600) begin
      errors++;
      $display("FAIL hlt_clear: tstate=%0d halted=%b ctl=%h, required 1 0 600", tstate, halted, ctl);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_illegal();
    apply_reset();
    run_instr("nop7", 4'h7, LEN_NOP, EXP_NOP);
    apply_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ih_tstate !== 3'd4 || ih_halted !== 1'b0) begin
      errors++;
      $display("FAIL ill_halt_t4: tstate=%0d halted=%b, required 4 0", ih_tstate, ih_halted);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (ih_tstate !== 3'd4 || ih_halted !== 1'b1 || ih_ctl !== 12'h000) begin
      errors++;
      $display("FAIL ill_halt: tstate=%0d halted=%b ctl=%h, required 4 1 000",
               ih_tstate, ih_halted, ih_ctl);
    end
    checks++;
    if (tstate !== 3'(NOP_AFTER_T4) || halted !== 1'b0) begin
      errors++;
      $display("FAIL ill_nop_runs: tstate=%0d halted=%b, required %0d 0",
               tstate, halted, NOP_AFTER_T4);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (ih_halted !== 1'b0 || ih_tstate !== 3'd1) begin
      errors++;
      $display("FAIL ill_clear: tstate=%0d halted=%b, required 1 0", ih_tstate, ih_halted);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    opcode = 4'h0;
    test_reset();
    test_add();
    test_sub();
    test_out();
    test_back_to_back();
    test_hlt();
    test_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
